multicycle_mem_arbiter: RTL and testbench

MULTICYCLE_MEM_ARBITER -- requirements
Module: multicycle_mem_arbiter

---
 rtl/multicycle_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_multicycle_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_mem_arbiter.sv
// Two-requester (core, DMA) arbiter for a single multicycle memory port.
// Round-robin tie break, per-transaction wait-cycle timeout with a sticky bus error.
module multicycle_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  // core requester
  input  logic                  i_core_req,
  input  logic                  i_core_we,
  input  logic [ADDR_WIDTH-1:0] i_core_addr,
  input  logic [31:0]           i_core_wdata,
  input  logic [3:0]            i_core_be,
  output logic                  o_core_ack,
  output logic                  o_core_err,
  output logic [31:0]           o_core_rdata,
  // DMA requester
  input  logic                  i_dma_req,
  input  logic                  i_dma_we,
  input  logic [ADDR_WIDTH-1:0] i_dma_addr,
  input  logic [31:0]           i_dma_wdata,
  input  logic [3:0]            i_dma_be,
  output logic                  o_dma_ack,
  output logic                  o_dma_err,
  output logic [31:0]           o_dma_rdata,
  // memory port
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic [3:0]            o_mem_be,
  input  logic                  i_mem_ack,
  input  logic [31:0]           i_mem_rdata,
  // error reporting
  input  logic                  i_error_clear,
  output logic                  o_bus_error
);

  localparam int unsigned CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUSY_CORE = 2'd1,
    ST_BUSY_DMA  = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_last_dma;
  logic [CNT_WIDTH-1:0]  r_wait_cnt;
  logic                  r_bus_error;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic [3:0]            r_mem_be;

  logic w_busy;
  logic w_timeout;
  logic w_done;
  logic w_grant_core;
  logic w_grant_dma;

  // Transaction end: memory ack wins over a coincident timeout.
  assign w_busy       = (r_state != ST_IDLE);
  assign w_timeout    = w_busy && !i_mem_ack && (r_wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES));
  assign w_done       = w_busy && (i_mem_ack || w_timeout);
  // Tie goes to whoever was not granted last.
  assign w_grant_core = i_core_req && (!i_dma_req || r_last_dma);
  assign w_grant_dma  = i_dma_req && (!i_core_req || !r_last_dma);

  // Arbitration FSM, wait counter, latched memory command and sticky error.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_last_dma  <= 1'b1;
      r_wait_cnt  <= '0;
      r_bus_error <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_core) begin
            r_state     <= ST_BUSY_CORE;
            r_last_dma  <= 1'b0;
            r_wait_cnt  <= '0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= i_core_we;
            r_mem_addr  <= i_core_addr;
            r_mem_wdata <= i_core_wdata;
            r_mem_be    <= i_core_be;
          end else if (w_grant_dma) begin
            r_state     <= ST_BUSY_DMA;
            r_last_dma  <= 1'b1;
            r_wait_cnt  <= '0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= i_dma_we;
            r_mem_addr  <= i_dma_addr;
            r_mem_wdata <= i_dma_wdata;
            r_mem_be    <= i_dma_be;
          end
        end
        default: begin
          if (w_done) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_WIDTH'(1);
          end
        end
      endcase

      if (w_timeout) begin
        r_bus_error <= 1'b1;
      end else if (i_error_clear) begin
        r_bus_error <= 1'b0;
      end
    end
  end

  // Completion signalling back to the owning requester, same cycle as mem_ack/timeout.
  always_comb begin
    o_core_ack   = 1'b0;
    o_core_err   = 1'b0;
    o_core_rdata = '0;
    o_dma_ack    = 1'b0;
    o_dma_err    = 1'b0;
    o_dma_rdata  = '0;
    if (!i_reset && w_done) begin
      if (r_state == ST_BUSY_CORE) begin
        o_core_ack   = 1'b1;
        o_core_err   = w_timeout;
        o_core_rdata = w_timeout ? 32'd0 : i_mem_rdata;
      end else if (r_state == ST_BUSY_DMA) begin
        o_dma_ack    = 1'b1;
        o_dma_err    = w_timeout;
        o_dma_rdata  = w_timeout ? 32'd0 : i_mem_rdata;
      end
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_be    = r_mem_be;
  assign o_bus_error = r_bus_error;

endmodule

// File: tb/tb_multicycle_mem_arbiter.sv
// Bench for multicycle_mem_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_multicycle_mem_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned TMO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req, core_we, dma_req, dma_we;
  logic [AW-1:0] core_addr, dma_addr, mem_addr;
  logic [31:0]   core_wdata, dma_wdata, mem_wdata, mem_rdata;
  logic [3:0]    core_be, dma_be, mem_be;
  logic          core_ack, core_err, dma_ack, dma_err;
  logic [31:0]   core_rdata, dma_rdata;
  logic          mem_req, mem_we, mem_ack, error_clear, bus_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_mem_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clock(clk), .i_reset(reset),
    .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr),
    .i_core_wdata(core_wdata), .i_core_be(core_be),
    .o_core_ack(core_ack), .o_core_err(core_err), .o_core_rdata(core_rdata),
    .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr),
    .i_dma_wdata(dma_wdata), .i_dma_be(dma_be),
    .o_dma_ack(dma_ack), .o_dma_err(dma_err), .o_dma_rdata(dma_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .i_error_clear(error_clear), .o_bus_error(bus_error)
  );

  // Reference model: who owns the memory (0 none, 1 core, 2 dma), the command
  // they were granted with, how many cycles they have waited, and who won last.
  int          m_owner;
  int          m_waited;
  bit          m_last_dma;
  bit          m_bus_err;
  bit          m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  bit          m_tmo, m_done;
  bit          e_core_ack, e_core_err, e_dma_ack, e_dma_err;
  logic [31:0] e_core_rdata, e_dma_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Let inputs settle, derive the expected outputs for this cycle and compare.
  task automatic settle();
    #3;
    m_tmo  = (m_owner != 0) && !mem_ack && (m_waited == int'(TMO));
    m_done = (m_owner != 0) && (mem_ack || m_tmo);
    e_core_ack   = !reset && m_done && (m_owner == 1);
    e_dma_ack    = !reset && m_done && (m_owner == 2);
    e_core_err   = e_core_ack && m_tmo;
    e_dma_err    = e_dma_ack && m_tmo;
    e_core_rdata = (e_core_ack && !m_tmo) ? mem_rdata : 32'd0;
    e_dma_rdata  = (e_dma_ack && !m_tmo) ? mem_rdata : 32'd0;
    chk("mem_req", mem_req, m_owner != 0);
    if (m_owner != 0) begin
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_be", mem_be, m_be);
    end
    chk("core_ack", core_ack, e_core_ack);
    chk("core_err", core_err, e_core_err);
    chk("core_rdata", core_rdata, e_core_rdata);
    chk("dma_ack", dma_ack, e_dma_ack);
    chk("dma_err", dma_err, e_dma_err);
    chk("dma_rdata", dma_rdata, e_dma_rdata);
    chk("bus_error", bus_error, m_bus_err);
  endtask

  // Apply this cycle's inputs to the model, then move to the next cycle.
  task automatic advance();
    if (reset) begin
      m_owner = 0; m_waited = 0; m_last_dma = 1'b1; m_bus_err = 1'b0;
    end else begin
      if (m_tmo) m_bus_err = 1'b1;
      else if (error_clear) m_bus_err = 1'b0;
      if (m_owner != 0) begin
        if (m_done) m_owner = 0;
        else m_waited++;
      end else if (core_req && (!dma_req || m_last_dma)) begin
        m_owner = 1; m_waited = 0; m_last_dma = 1'b0;
        m_we = core_we; m_addr = core_addr; m_wdata = core_wdata; m_be = core_be;
      end else if (dma_req) begin
        m_owner = 2; m_waited = 0; m_last_dma = 1'b1;
        m_we = dma_we; m_addr = dma_addr; m_wdata = dma_wdata; m_be = dma_be;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_be = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_be = '0;
    mem_ack = 0; mem_rdata = '0; error_clear = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    settle();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_core_ack", core_ack, 1'b0);
    advance();
    reset = 0;
  endtask

  initial begin
    int hi;
    reset = 1;
    idle_inputs();
    m_owner = 0; m_waited = 0; m_last_dma = 1'b1; m_bus_err = 1'b0;
    m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
    @(posedge clk);
    #1;
    settle();
    chk("reset_bus_error", bus_error, 1'b0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    advance();
    reset = 0;

    // Core read with three wait cycles.
    core_req = 1; core_we = 0; core_addr = 32'h100;
    settle();
    chk("r32_idle_mem_req", mem_req, 1'b0);
    advance();
    hi = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      if (mem_req) hi++;
      chk("r32_wait_ack", core_ack, 1'b0);
      advance();
    end
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    settle();
    if (mem_req) hi++;
    chk("r32_core_ack", core_ack, 1'b1);
    chk("r32_core_rdata", core_rdata, 32'hDEADBEEF);
    chk("r32_dma_ack", dma_ack, 1'b0);
    chk("r32_mem_req_cycles", hi, 4);
    advance();
    idle_inputs();
    settle();
    chk("r32_after_mem_req", mem_req, 1'b0);
    advance();

    // Alternation after reset.
    do_reset();
    core_req = 1; core_addr = 32'hC0;
    dma_req = 1; dma_addr = 32'hD0; dma_we = 1; dma_wdata = 32'h55; dma_be = 4'hF;
    step();
    mem_ack = 1;
    settle();
    chk("r33_first_core", core_ack, 1'b1);
    chk("r33_first_addr", mem_addr, 32'hC0);
    chk("r33_first_dma", dma_ack, 1'b0);
    advance();
    core_req = 0; mem_ack = 0;
    step();
    mem_ack = 1;
    settle();
    chk("r33_second_dma", dma_ack, 1'b1);
    chk("r33_second_addr", mem_addr, 32'hD0);
    advance();
    core_req = 1; mem_ack = 0;
    step();
    mem_ack = 1;
    settle();
    chk("r33_third_core", core_ack, 1'b1);
    chk("r33_third_dma", dma_ack, 1'b0);
    advance();
    idle_inputs();
    step();

    // DMA write, command held stable while waiting.
    dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h12345678; dma_be = 4'b0011;
    step();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("r34_mem_we", mem_we, 1'b1);
      chk("r34_mem_addr", mem_addr, 32'h20);
      chk("r34_mem_wdata", mem_wdata, 32'h12345678);
      chk("r34_mem_be", mem_be, 4'b0011);
      advance();
    end
    mem_ack = 1;
    settle();
    chk("r34_dma_ack", dma_ack, 1'b1);
    advance();
    idle_inputs();
    step();

    // Timeout: memory never answers.
    core_req = 1; core_addr = 32'h44; mem_rdata = 32'hFFFFFFFF;
    step();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("r35_no_ack_yet", core_ack, 1'b0);
      advance();
    end
    settle();
    chk("r35_ack", core_ack, 1'b1);
    chk("r35_err", core_err, 1'b1);
    chk("r35_rdata", core_rdata, 32'd0);
    advance();
    core_req = 0;
    settle();
    chk("r35_mem_req_low", mem_req, 1'b0);
    chk("r35_bus_error", bus_error, 1'b1);
    advance();
    step();
    error_clear = 1;
    settle();
    chk("r35_still_set", bus_error, 1'b1);
    advance();
    error_clear = 0;
    settle();
    chk("r35_cleared", bus_error, 1'b0);
    advance();

    // Ack coincident with the timeout count.
    core_req = 1; mem_rdata = 32'hA5A5A5A5;
    step();
    for (int i = 0; i < 4; i++) step();
    mem_ack = 1;
    settle();
    chk("r36_ack", core_ack, 1'b1);
    chk("r36_err", core_err, 1'b0);
    chk("r36_rdata", core_rdata, 32'hA5A5A5A5);
    advance();
    core_req = 0; mem_ack = 0;
    settle();
    chk("r36_no_bus_error", bus_error, 1'b0);
    advance();

    // Reset in the middle of a transaction.
    core_req = 1;
    step();
    step();
    reset = 1; mem_ack = 1;
    settle();
    chk("r36_rst_no_ack", core_ack, 1'b0);
    advance();
    reset = 0; core_req = 0; mem_ack = 1;
    settle();
    chk("r36_rst_mem_req", mem_req, 1'b0);
    chk("r36_stray_core", core_ack, 1'b0);
    chk("r36_stray_dma", dma_ack, 1'b0);
    advance();
    mem_ack = 0;
    settle();
    chk("r36_stray_ignored", mem_req, 1'b0);
    advance();

    // Randomized traffic: requesters hold until acked, memory acks at random.
    idle_inputs();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 299) == 0);
      error_clear = ($urandom_range(0, 15) == 0);
      if (!core_req && $urandom_range(0, 2) == 0) begin
        core_req = 1; core_we = 1'($urandom); core_addr = $urandom;
        core_wdata = $urandom; core_be = 4'($urandom);
      end
      if (!dma_req && $urandom_range(0, 2) == 0) begin
        dma_req = 1; dma_we = 1'($urandom); dma_addr = $urandom;
        dma_wdata = $urandom; dma_be = 4'($urandom);
      end
      mem_ack = (m_owner != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
      settle();
      if (e_core_ack) core_req = 0;
      if (e_dma_ack) dma_req = 0;
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
